// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer data-path blocks: default BCD
// converter geometry and the converter state encoding.
package accel_pkg;

  localparam int ACCEL_NUM_DIGITS = 4;
  localparam int ACCEL_BIN_W      = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  function automatic logic bcd_nibble_bad(input logic [3:0] nibble);
    return nibble > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction slice: a nibble that reached 8 or more
// after the right shift gets 3 subtracted.
module bcd_digit_adjust (
  input  logic [3:0] nibble_in,
  output logic [3:0] nibble_out
);

  assign nibble_out = (nibble_in >= 4'd8) ? (nibble_in - 4'd3) : nibble_in;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one shift/adjust step per clock, BIN_W steps per conversion.
module bcd_to_binary
  import accel_pkg::*;
#(
  parameter int NUM_DIGITS = ACCEL_NUM_DIGITS,
  parameter int BIN_W      = ACCEL_BIN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  conv_state_e        state_q, state_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;

  logic [WORK_W-1:0]  shifted;
  logic [BCD_W-1:0]   adj_bcd;
  logic [WORK_W-1:0]  stepped;
  logic               bad_digit;

  // Working register is {BCD field, binary field}; BCD bits migrate into the binary field.
  assign shifted = work_q >> 1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .nibble_in  (shifted[BIN_W + 4*g +: 4]),
      .nibble_out (adj_bcd[4*g +: 4])
    );
  end

  assign stepped = {adj_bcd, shifted[BIN_W-1:0]};

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_nibble_bad(bcd_in[4*i +: 4])) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      ST_CONV: begin
        work_d = stepped;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          bin_d   = stepped[BIN_W-1:0];
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (Load) begin
          cnt_d = '0;
          if (bad_digit) begin
            work_d  = '0;
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            work_d  = {bcd_in, {BIN_W{1'b0}}};
            state_d = ST_CONV;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign err     = err_q;
  assign busy    = (state_q == ST_CONV);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed corner cases plus random
// packed-BCD operands compared against a decimal arithmetic reference model.
module tb_bcd_to_binary;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    Load = 1'b0;
  logic [4*NUM_DIGITS-1:0] bcd_in = '0;
  logic [BIN_W-1:0]        bin_out;
  logic                    busy;
  logic                    done;
  logic                    err;

  int checkCount = 0;
  int failCount = 0;
  int overlapCount = 0;
  int holdViolations = 0;
  int lastBin = 0;
  bit lastErr = 0;

  bcd_to_binary #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Load    (Load),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) overlapCount++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  // Decimal value of the packed digits; any digit above 9 flags an error and yields 0.
  function automatic void refModel(input logic [15:0] bcd, output int value, output bit bad);
    int d;
    value = 0;
    bad = 0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) bad = 1;
      value = value * 10 + d;
    end
    if (bad) value = 0;
  endfunction

  task automatic applyStimulus(input logic [15:0] v, input bit holdLoad);
    @(negedge clk);
    bcd_in = v;
    Load = 1'b1;
    @(posedge clk);
    #1;
    if (!holdLoad) Load = 1'b0;
  endtask

  // Latency counts negedges after the capture edge: 0 means done already visible after it.
  task automatic waitDone(input int budget, input int changeAt, input logic [15:0] newBcd,
                          output int latency, output bit sawBusy);
    latency = -1;
    sawBusy = 0;
    for (int n = 0; n <= budget; n++) begin
      @(negedge clk);
      if (n == changeAt) bcd_in = newBcd;
      if (busy) sawBusy = 1;
      if (done) begin
        latency = n;
        break;
      end
      if (int'(bin_out) != lastBin || err !== lastErr) holdViolations++;
    end
  endtask

  task automatic finishCheck(input string tag, input int expVal, input bit expBad,
                             input int latency, input bit sawBusy);
    checkOutput({tag, "_latency"}, latency, expBad ? 0 : BIN_W);
    checkOutput({tag, "_bin_out"}, bin_out, expVal);
    checkOutput({tag, "_err"}, err, expBad);
    checkOutput({tag, "_busy_seen"}, sawBusy, !expBad);
    lastBin = expVal;
    lastErr = expBad;
  endtask

  task automatic runConversion(input logic [15:0] v, input string tag);
    int expVal, lat;
    bit expBad, sawBusy;
    refModel(v, expVal, expBad);
    applyStimulus(v, 0);
    waitDone(40, -1, '0, lat, sawBusy);
    finishCheck(tag, expVal, expBad, lat, sawBusy);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, done, 0);
    checkOutput({tag, "_bin_hold"}, bin_out, expVal);
  endtask

  initial begin
    int lat, doneSeen;
    bit sawBusy;
    logic [15:0] v;

    repeat (3) @(negedge clk);
    checkOutput("reset_bin_out", bin_out, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    runConversion(16'h9999, "max_9999");
    runConversion(16'h1234, "val_1234");
    runConversion(16'h0000, "zero");
    runConversion(16'h00A5, "bad_00A5");
    runConversion(16'h0007, "after_err");

    // Load stays high: CONV must ignore the bcd_in change, DONE must restart back-to-back.
    applyStimulus(16'h0500, 1);
    waitDone(40, 5, 16'h0001, lat, sawBusy);
    finishCheck("held_first", 500, 0, lat, sawBusy);
    @(posedge clk);
    #1;
    Load = 1'b0;
    waitDone(40, -1, '0, lat, sawBusy);
    finishCheck("held_second", 1, 0, lat, sawBusy);
    @(negedge clk);
    checkOutput("held_done_pulse", done, 0);

    // Reset in the middle of a conversion abandons it silently.
    applyStimulus(16'h4321, 0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_bin_out", bin_out, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_err", err, 0);
    lastBin = 0;
    lastErr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("midrst_no_done", doneSeen, 0);
    runConversion(16'h0042, "after_reset");

    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if ($urandom_range(0, 7) == 0) v[4*d +: 4] = 4'($urandom_range(10, 15));
        else v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      runConversion(v, $sformatf("rand%0d", i));
    end

    checkOutput("busy_done_overlap", overlapCount, 0);
    checkOutput("output_hold", holdViolations, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
